branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequencer between the execute-stage jump unit and instruction fetch. Accepts resolved jump results (near/far/conditional target, CS load, misprediction flag) over a valid/ready handshake, holds the pipeline flush for a fixed number of cycles, then presents a single redirect (EIP, optional CS) to fetch and waits for acceptance. While a redirect is in flight it back-pressures execute, so only one control transfer is ever pending.

## Interface

Parameters:
- FLUSH_CYCLES, 2, cycles `flush` is held asserted per redirect; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute presents a resolved instruction this cycle.
- ex_ready  out  1  controller can accept (combinational from state).
- jump_load_address  in  1  instruction redirects EIP to jump_address.
- jump_address  in  32  target EIP, already opsize-masked.
- jump_load_cs  in  1  far jump; load CS as well.
- jump_cs  in  32  new CS value (low 16 bits significant).
- br_misprediction  in  1  predicted direction was wrong.
- ex_next_eip  in  32  fall-through EIP of the instruction.
- flush  out  1  kill all younger in-flight instructions.
- redirect_valid  out  1  redirect offered to fetch.
- fetch_ready  in  1  fetch accepts redirect.
- redirect_eip  out  32  new fetch EIP.
- redirect_load_cs  out  1  fetch also loads CS.
- redirect_cs  out  32  new CS.
- redirect_count  out  32  redirects issued (see Configuration).
- mispredict_count  out  32  mispredictions seen (see Configuration).

## Operation

- States: IDLE, FLUSH, REDIRECT (2-bit encoded).
- Accept = ex_valid & ex_ready; ex_ready = 1 only in IDLE.
- Redirect condition on accept: jump_load_address | jump_load_cs | br_misprediction.
- Target select at accept: jump_load_address | jump_load_cs → jump_address; else (misprediction of a predicted-taken branch that fell through) → ex_next_eip.
- On accept with redirect condition: capture target into redirect_eip, jump_cs into redirect_cs, jump_load_cs into redirect_load_cs; load flush counter with FLUSH_CYCLES−1; go FLUSH.
- On accept without redirect condition: stay IDLE, no outputs change.
- FLUSH: flush=1; counter decrements each cycle; at counter==0 go REDIRECT next cycle.
- REDIRECT: redirect_valid=1, payload held stable; on fetch_ready go IDLE next cycle, clearing redirect_valid and redirect_load_cs.
- redirect_eip/redirect_cs hold last value in IDLE (don't-care to fetch when redirect_valid=0).
- fetch_ready ignored outside REDIRECT; ex_valid ignored outside IDLE (execute must hold).

## Timing

- Reset (async, any state): state=IDLE, flush=0, redirect_valid=0, redirect_load_cs=0, redirect_eip=0, redirect_cs=0, counter=0, both perf counters=0; ex_ready=1 immediately.
- Accept at cycle N → flush high cycles N+1..N+FLUSH_CYCLES → redirect_valid high from N+FLUSH_CYCLES+1.
- fetch_ready at redirect cycle M (handshake) → IDLE at M+1, next accept possible at M+1.
- Minimum redirect-to-redirect spacing: FLUSH_CYCLES+2 cycles.
- flush and redirect_valid never asserted in the same cycle.
- Reset asserted mid-FLUSH or mid-REDIRECT aborts the transfer; no redirect issued.

## Configuration

- BR_REDIRECT_PERF_EN defined: redirect_count increments on every REDIRECT handshake; mispredict_count increments on every accept with br_misprediction=1; both saturate at 32'hFFFFFFFF.
- Undefined: counter registers not built; redirect_count and mispredict_count tied to 0.

## Test plan

- Near jump: FLUSH_CYCLES=2, accept jump_load_address=1, jump_address=32'h0000_1040 at cycle 5 → flush high cycles 6–7, redirect_valid high cycle 8 with redirect_eip=32'h1040, redirect_load_cs=0; fetch_ready at 8 → ex_ready=1 at 9.
- Far jump: jump_load_cs=1, jump_cs=32'h0000_0023, jump_address=32'h0000_2000 → redirect_load_cs=1, redirect_cs=32'h23, redirect_eip=32'h2000 until fetch_ready.
- Not-taken mispredict: br_misprediction=1, jump_load_address=0, ex_next_eip=32'h0000_3005 → redirect_eip=32'h3005; mispredict_count=1 with BR_REDIRECT_PERF_EN.
- Back-pressure: fetch_ready low for 4 cycles in REDIRECT while ex_valid=1 with another jump → ex_ready=0 throughout, payload stable; second jump accepted cycle after handshake.
- Non-branch traffic: ex_valid=1 every cycle, all jump inputs 0 → ex_ready stays 1, flush and redirect_valid never asserted, counters stay 0.
- Reset mid-FLUSH: drop reset during flush cycle 1 → flush=0, redirect_valid=0, ex_ready=1 asynchronously; no redirect after release.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Redirect sequencer between the execute-stage jump unit and fetch: flush for FLUSH_CYCLES, then offer one redirect.
// Optional perf counters are built when BR_REDIRECT_PERF_EN is defined; otherwise both counter outputs are tied to 0.
module branch_redirect_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        jump_load_address,
    input  logic [31:0] jump_address,
    input  logic        jump_load_cs,
    input  logic [31:0] jump_cs,
    input  logic        br_misprediction,
    input  logic [31:0] ex_next_eip,
    output logic        flush,
    output logic        redirect_valid,
    input  logic        fetch_ready,
    output logic [31:0] redirect_eip,
    output logic        redirect_load_cs,
    output logic [31:0] redirect_cs,
    output logic [31:0] redirect_count,
    output logic [31:0] mispredict_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_e      state_q;
    logic [3:0]  flush_cnt_q;
    logic        flush_q;
    logic        redirect_valid_q;
    logic        redirect_load_cs_q;
    logic [31:0] redirect_eip_q;
    logic [31:0] redirect_cs_q;

    logic        accept;
    logic        redirect_req;
    logic        handshake;
    logic [31:0] target_eip;

    assign ex_ready     = (state_q == ST_IDLE);
    assign accept       = ex_valid & ex_ready;
    assign redirect_req = jump_load_address | jump_load_cs | br_misprediction;
    assign handshake    = (state_q == ST_REDIRECT) & fetch_ready;

    // A mispredict with no load means a predicted-taken branch actually fell through.
    assign target_eip = (jump_load_address | jump_load_cs) ? jump_address : ex_next_eip;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= ST_IDLE;
            flush_cnt_q        <= 4'd0;
            flush_q            <= 1'b0;
            redirect_valid_q   <= 1'b0;
            redirect_load_cs_q <= 1'b0;
            redirect_eip_q     <= 32'd0;
            redirect_cs_q      <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && redirect_req) begin
                        state_q            <= ST_FLUSH;
                        flush_q            <= 1'b1;
                        flush_cnt_q        <= FLUSH_LOAD;
                        redirect_eip_q     <= target_eip;
                        redirect_cs_q      <= jump_cs;
                        redirect_load_cs_q <= jump_load_cs;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == 4'd0) begin
                        state_q          <= ST_REDIRECT;
                        flush_q          <= 1'b0;
                        redirect_valid_q <= 1'b1;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                    end
                end
                ST_REDIRECT: begin
                    if (fetch_ready) begin
                        state_q            <= ST_IDLE;
                        redirect_valid_q   <= 1'b0;
                        redirect_load_cs_q <= 1'b0;
                    end
                end
                default: begin
                    state_q            <= ST_IDLE;
                    flush_q            <= 1'b0;
                    redirect_valid_q   <= 1'b0;
                    redirect_load_cs_q <= 1'b0;
                end
            endcase
        end
    end

    assign flush            = flush_q;
    assign redirect_valid   = redirect_valid_q;
    assign redirect_load_cs = redirect_load_cs_q;
    assign redirect_eip     = redirect_eip_q;
    assign redirect_cs      = redirect_cs_q;

`ifdef BR_REDIRECT_PERF_EN
    logic [31:0] redirect_count_q;
    logic [31:0] redirect_count_d;
    logic [31:0] mispredict_count_q;
    logic [31:0] mispredict_count_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        redirect_count_d   = redirect_count_q;
        mispredict_count_d = mispredict_count_q;
        if (handshake && (redirect_count_q != 32'hFFFF_FFFF))
            redirect_count_d = redirect_count_q + 32'd1;
        if (accept && br_misprediction && (mispredict_count_q != 32'hFFFF_FFFF))
            mispredict_count_d = mispredict_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_count_q   <= 32'd0;
            mispredict_count_q <= 32'd0;
        end else begin
            redirect_count_q   <= redirect_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign redirect_count   = redirect_count_q;
    assign mispredict_count = mispredict_count_q;
`else
    assign redirect_count   = 32'd0;
    assign mispredict_count = 32'd0;
`endif

    a_flush_redirect_excl: assert property (@(posedge clk) disable iff (!reset)
        !(flush && redirect_valid));

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: near/far/mispredict redirects, back-pressure, plain traffic, reset abort.
module tb_branch_redirect_ctrl;

    localparam int FC = 2;
`ifdef BR_REDIRECT_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        jump_load_address = 1'b0;
    logic [31:0] jump_address = 32'd0;
    logic        jump_load_cs = 1'b0;
    logic [31:0] jump_cs = 32'd0;
    logic        br_misprediction = 1'b0;
    logic [31:0] ex_next_eip = 32'd0;
    logic        flush;
    logic        redirect_valid;
    logic        fetch_ready = 1'b0;
    logic [31:0] redirect_eip;
    logic        redirect_load_cs;
    logic [31:0] redirect_cs;
    logic [31:0] redirect_count;
    logic [31:0] mispredict_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_redir = 0;
    int exp_mis = 0;

    branch_redirect_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .jump_load_address(jump_load_address), .jump_address(jump_address),
        .jump_load_cs(jump_load_cs), .jump_cs(jump_cs),
        .br_misprediction(br_misprediction), .ex_next_eip(ex_next_eip),
        .flush(flush), .redirect_valid(redirect_valid), .fetch_ready(fetch_ready),
        .redirect_eip(redirect_eip), .redirect_load_cs(redirect_load_cs),
        .redirect_cs(redirect_cs), .redirect_count(redirect_count),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs and checks happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("flush_rv_excl", {31'd0, flush & redirect_valid}, 32'd0);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_rcnt"}, redirect_count, PERF ? 32'(exp_redir) : 32'd0);
        chk({tag, "_mcnt"}, mispredict_count, PERF ? 32'(exp_mis) : 32'd0);
    endtask

    task automatic present(input logic la, input logic lcs, input logic mis,
                           input logic [31:0] addr, input logic [31:0] cs, input logic [31:0] nxt);
        ex_valid = 1'b1; jump_load_address = la; jump_load_cs = lcs; br_misprediction = mis;
        jump_address = addr; jump_cs = cs; ex_next_eip = nxt;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; jump_load_address = 1'b0; jump_load_cs = 1'b0; br_misprediction = 1'b0;
    endtask

    // Accept now, check FC flush cycles, land in the first redirect cycle.
    task automatic accept_and_flush(input string tag, input logic mis);
        chk({tag, "_ready"}, {31'd0, ex_ready}, 32'd1);
        tick();
        if (mis) exp_mis++;
        idle_inputs();
        for (int i = 0; i < FC; i++) begin
            chk({tag, "_flush"}, {31'd0, flush}, 32'd1);
            chk({tag, "_rv_low"}, {31'd0, redirect_valid}, 32'd0);
            chk({tag, "_busy"}, {31'd0, ex_ready}, 32'd0);
            tick();
        end
        chk({tag, "_rv"}, {31'd0, redirect_valid}, 32'd1);
        chk({tag, "_flush_off"}, {31'd0, flush}, 32'd0);
    endtask

    task automatic handshake(input string tag);
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        exp_redir++;
        chk({tag, "_rv_done"}, {31'd0, redirect_valid}, 32'd0);
        chk({tag, "_lcs_done"}, {31'd0, redirect_load_cs}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, ex_ready}, 32'd1);
    endtask

    initial begin
        // Reset state, including immediate ex_ready.
        #2;
        chk("rst_ready", {31'd0, ex_ready}, 32'd1);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
        chk("rst_eip", redirect_eip, 32'd0);
        chk("rst_cs", redirect_cs, 32'd0);
        chk("rst_lcs", {31'd0, redirect_load_cs}, 32'd0);
        chk_counts("rst");
        tick(); tick();
        reset = 1'b1;
        tick();

        // Near jump.
        present(1'b1, 1'b0, 1'b0, 32'h0000_1040, 32'h0000_0077, 32'h0000_0100);
        accept_and_flush("near", 1'b0);
        chk("near_eip", redirect_eip, 32'h0000_1040);
        chk("near_lcs", {31'd0, redirect_load_cs}, 32'd0);
        handshake("near");
        chk_counts("near");

        // Far jump, payload held while fetch stalls.
        present(1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_0023, 32'h0000_0200);
        accept_and_flush("far", 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("far_eip", redirect_eip, 32'h0000_2000);
            chk("far_cs", redirect_cs, 32'h0000_0023);
            chk("far_lcs", {31'd0, redirect_load_cs}, 32'd1);
            tick();
        end
        chk("far_rv_hold", {31'd0, redirect_valid}, 32'd1);
        handshake("far");
        chk("far_cs_hold", redirect_cs, 32'h0000_0023);
        chk_counts("far");

        // Predicted-taken branch that fell through.
        present(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'd0, 32'h0000_3005);
        accept_and_flush("mis", 1'b1);
        chk("mis_eip", redirect_eip, 32'h0000_3005);
        chk("mis_lcs", {31'd0, redirect_load_cs}, 32'd0);
        handshake("mis");
        chk_counts("mis");

        // Back-pressure: second jump held by execute until the cycle after the handshake.
        present(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'd0, 32'd0);
        tick();
        present(1'b1, 1'b0, 1'b0, 32'h0000_5000, 32'd0, 32'd0);
        for (int i = 0; i < FC; i++) begin
            chk("bp_flush", {31'd0, flush}, 32'd1);
            chk("bp_busy_f", {31'd0, ex_ready}, 32'd0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            chk("bp_rv", {31'd0, redirect_valid}, 32'd1);
            chk("bp_busy_r", {31'd0, ex_ready}, 32'd0);
            chk("bp_eip", redirect_eip, 32'h0000_1000);
            tick();
        end
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        exp_redir++;
        chk("bp_ready2", {31'd0, ex_ready}, 32'd1);
        chk("bp_eip_kept", redirect_eip, 32'h0000_1000);
        tick();
        idle_inputs();
        chk("bp2_flush", {31'd0, flush}, 32'd1);
        for (int i = 1; i < FC; i++) tick();
        tick();
        chk("bp2_rv", {31'd0, redirect_valid}, 32'd1);
        chk("bp2_eip", redirect_eip, 32'h0000_5000);
        handshake("bp2");
        chk_counts("bp");

        // Non-branch traffic never disturbs the controller.
        present(1'b0, 1'b0, 1'b0, 32'h0000_9999, 32'h0000_0011, 32'h0000_8888);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("nb_ready", {31'd0, ex_ready}, 32'd1);
            chk("nb_flush", {31'd0, flush}, 32'd0);
            chk("nb_rv", {31'd0, redirect_valid}, 32'd0);
        end
        chk("nb_eip", redirect_eip, 32'h0000_5000);
        chk_counts("nb");
        idle_inputs();

        // Reset during the first flush cycle aborts the transfer.
        present(1'b1, 1'b0, 1'b0, 32'h0000_7000, 32'd0, 32'd0);
        tick();
        idle_inputs();
        chk("ra_flush_pre", {31'd0, flush}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        exp_redir = 0;
        exp_mis = 0;
        chk("ra_flush", {31'd0, flush}, 32'd0);
        chk("ra_rv", {31'd0, redirect_valid}, 32'd0);
        chk("ra_ready", {31'd0, ex_ready}, 32'd1);
        chk("ra_eip", redirect_eip, 32'd0);
        chk_counts("ra");
        tick();
        reset = 1'b1;
        for (int i = 0; i < FC + 3; i++) begin
            tick();
            chk("ra_no_rv", {31'd0, redirect_valid}, 32'd0);
            chk("ra_no_flush", {31'd0, flush}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
